// File: rtl/npu_out_pack.sv
// Requantize-and-pack stage: shifts/rounds/saturates signed accumulators to int8
// and packs LANES of them per output word on a single-entry valid/ready slot.
module npu_out_pack #(
    parameter int AXI_WIDTH   = 64,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_pulse,
    input  logic [31:0]            total_len,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic                   round_en,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            word_count,
    input  logic [ACC_WIDTH-1:0]   acc_in,
    input  logic                   acc_valid,
    output logic                   acc_ready,
    output logic [AXI_WIDTH-1:0]   data_from_npu,
    output logic                   data_from_npu_valid,
    input  logic                   data_from_npu_ready
);

    localparam int LANES  = AXI_WIDTH / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic signed [ACC_WIDTH:0] QMAX = 127;
    localparam logic signed [ACC_WIDTH:0] QMIN = -128;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [31:0]            elems_left_q, elems_left_d;
    logic [AXI_WIDTH-1:0]   pack_q, pack_d;
    logic [AXI_WIDTH-1:0]   out_q, out_d;
    logic                   out_vld_q, out_vld_d;
    logic [31:0]            word_count_q, word_count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   round_q, round_d;

    logic signed [ACC_WIDTH:0] rnd, t, q_full;
    logic [7:0]                q8;
    logic [AXI_WIDTH-1:0]      packed_nxt;
    logic                      complete, ready_int, accept, out_hs;

    // Quantizer: one extra bit of headroom so the rounding add cannot overflow.
    always_comb begin
        rnd    = '0;
        if (round_q && shift_q != '0)
            rnd = (ACC_WIDTH+1)'(1) << (shift_q - 1'b1);
        t      = $signed({acc_in[ACC_WIDTH-1], acc_in}) + rnd;
        q_full = t >>> shift_q;
        if (32'(shift_q) >= ACC_WIDTH)
            q8 = acc_in[ACC_WIDTH-1] ? 8'hFF : 8'h00;
        else if (q_full > QMAX)
            q8 = 8'h7F;
        else if (q_full < QMIN)
            q8 = 8'h80;
        else
            q8 = q_full[7:0];
    end

    always_comb begin
        packed_nxt = pack_q;
        for (int k = 0; k < LANES; k++)
            if (lane_q == LANE_W'(k))
                packed_nxt[8*k +: 8] = q8;
    end

    assign complete  = (lane_q == LANE_W'(LANES-1)) || (elems_left_q == 32'd1);
    assign out_hs    = out_vld_q && data_from_npu_ready;
    assign ready_int = (state_q == RUN) && (!complete || !out_vld_q || data_from_npu_ready);
    assign accept    = acc_valid && ready_int;

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        elems_left_d = elems_left_q;
        pack_d       = pack_q;
        out_d        = out_q;
        busy_d       = busy_q;
        done_d       = done_q;
        shift_d      = shift_q;
        round_d      = round_q;
        word_count_d = word_count_q + {31'd0, out_hs};
        // A load in the same cycle as a handshake keeps the slot full.
        out_vld_d    = (accept && complete) ? 1'b1 : (out_hs ? 1'b0 : out_vld_q);

        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    elems_left_d = total_len;
                    shift_d      = shift;
                    round_d      = round_en;
                    word_count_d = '0;
                    lane_d       = '0;
                    pack_d       = '0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = (total_len == 32'd0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    elems_left_d = elems_left_q - 32'd1;
                    if (complete) begin
                        out_d  = packed_nxt;
                        lane_d = '0;
                        pack_d = '0;
                    end else begin
                        lane_d = lane_q + 1'b1;
                        pack_d = packed_nxt;
                    end
                    if (elems_left_q == 32'd1)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_vld_q || out_hs) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            elems_left_q <= '0;
            pack_q       <= '0;
            out_q        <= '0;
            out_vld_q    <= 1'b0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            shift_q      <= '0;
            round_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            elems_left_q <= elems_left_d;
            pack_q       <= pack_d;
            out_q        <= out_d;
            out_vld_q    <= out_vld_d;
            word_count_q <= word_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            shift_q      <= shift_d;
            round_q      <= round_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign word_count          = word_count_q;
    assign acc_ready           = ready_int;
    assign data_from_npu       = out_q;
    assign data_from_npu_valid = out_vld_q;

endmodule

// File: tb/tb_npu_out_pack.sv
// Directed bench for npu_out_pack: packing, saturation, rounding, tails,
// backpressure, zero-length jobs, ignored restarts and mid-job reset.
module tb_npu_out_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_pulse = 1'b0;
    logic [31:0] total_len = '0;
    logic [4:0]  shift = '0;
    logic        round_en = 1'b0;
    logic        busy, done;
    logic [31:0] word_count;
    logic [31:0] acc_in = '0;
    logic        acc_valid = 1'b0;
    logic        acc_ready;
    logic [63:0] data_from_npu;
    logic        data_from_npu_valid;
    logic        data_from_npu_ready = 1'b1;

    int ncmp = 0;
    int nerr = 0;
    logic [63:0] words[$];

    npu_out_pack dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .total_len(total_len),
        .shift(shift), .round_en(round_en), .busy(busy), .done(done),
        .word_count(word_count), .acc_in(acc_in), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .data_from_npu(data_from_npu),
        .data_from_npu_valid(data_from_npu_valid),
        .data_from_npu_ready(data_from_npu_ready)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so negedge sees the values the next edge uses.
    always @(negedge clk)
        if (!rst && data_from_npu_valid && data_from_npu_ready)
            words.push_back(data_from_npu);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] len, input logic [4:0] sh, input logic rnd);
        total_len   = len;
        shift       = sh;
        round_en    = rnd;
        start_pulse = 1'b1;
        cyc();
        start_pulse = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        int n = 0;
        acc_in    = v;
        acc_valid = 1'b1;
        while (!acc_ready && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) chk("send_timeout", 64'(n), 64'd0);
        cyc();
        acc_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) chk("done_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_wc",    64'(word_count), 64'd0);
        chk("rst_ready", 64'(acc_ready), 64'd0);
        chk("rst_vld",   64'(data_from_npu_valid), 64'd0);
        chk("rst_data",  data_from_npu, 64'd0);
        rst = 1'b0;
        cyc();

        // Basic pack
        words.delete();
        start(8, 0, 0);
        chk("basic_busy", 64'(busy), 64'd1);
        for (int i = 1; i <= 8; i++) send(32'(i));
        wait_done();
        chk("basic_nwords", 64'(words.size()), 64'd1);
        chk("basic_word", words.size() > 0 ? words[0] : 64'hX, 64'h0807060504030201);
        chk("basic_wc", 64'(word_count), 64'd1);
        chk("basic_busy_end", 64'(busy), 64'd0);
        cyc();

        // Saturation, partial word
        words.delete();
        start(4, 2, 0);
        send(32'd1000); send(-32'sd1000); send(32'd0); send(-32'sd4);
        wait_done();
        chk("sat_word", words.size() > 0 ? words[0] : 64'hX, 64'h00000000FF00807F);
        cyc();

        // Rounding on / off
        words.delete();
        start(2, 2, 1);
        send(32'd6); send(-32'sd6);
        wait_done();
        chk("rnd_on", words.size() > 0 ? words[0] : 64'hX, 64'h000000000000FF02);
        cyc();
        words.delete();
        start(2, 2, 0);
        send(32'd6); send(-32'sd6);
        wait_done();
        chk("rnd_off", words.size() > 0 ? words[0] : 64'hX, 64'h000000000000FE01);
        cyc();

        // Large shift: result follows sign
        words.delete();
        start(2, 31, 0);
        send(32'h7FFF_FFFF); send(32'h8000_0000);
        wait_done();
        chk("shift31", words.size() > 0 ? words[0] : 64'hX, 64'h000000000000FF00);
        cyc();

        // Partial tail
        words.delete();
        start(11, 0, 0);
        for (int i = 1; i <= 11; i++) send(32'(i));
        wait_done();
        chk("tail_nwords", 64'(words.size()), 64'd2);
        chk("tail_w0", words.size() > 0 ? words[0] : 64'hX, 64'h0807060504030201);
        chk("tail_w1", words.size() > 1 ? words[1] : 64'hX, 64'h00000000000B0A09);
        chk("tail_wc", 64'(word_count), 64'd2);
        cyc();

        // Backpressure
        words.delete();
        data_from_npu_ready = 1'b0;
        start(16, 0, 0);
        for (int i = 1; i <= 15; i++) send(32'(i));
        acc_in    = 32'd16;
        acc_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 0 || i == 9) begin
                chk("bp_ready_low", 64'(acc_ready), 64'd0);
                chk("bp_data_stable", data_from_npu, 64'h0807060504030201);
            end
        end
        chk("bp_vld", 64'(data_from_npu_valid), 64'd1);
        data_from_npu_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 64'(acc_ready), 64'd1);
        cyc();
        acc_valid = 1'b0;
        chk("bp_no_bubble", 64'(data_from_npu_valid), 64'd1);
        chk("bp_word2", data_from_npu, 64'h100F0E0D0C0B0A09);
        wait_done();
        chk("bp_nwords", 64'(words.size()), 64'd2);
        chk("bp_wc", 64'(word_count), 64'd2);
        cyc();

        // Full-rate: each send completes in exactly one cycle with ready high
        words.delete();
        start(8, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) chk("rate_ready", 64'(acc_ready), 64'd1);
            send(32'(i + 16));
        end
        wait_done();
        chk("rate_word", words.size() > 0 ? words[0] : 64'hX, 64'h1817161514131211);
        cyc();

        // Zero-length job
        words.delete();
        start(0, 0, 0);
        chk("zero_done_early", 64'(done), 64'd0);
        cyc();
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_wc", 64'(word_count), 64'd0);
        chk("zero_nwords", 64'(words.size()), 64'd0);
        cyc();

        // start_pulse during RUN is ignored
        words.delete();
        start(3, 0, 0);
        send(32'd5);
        start(8, 0, 0);
        send(32'd6); send(32'd7);
        wait_done();
        chk("restart_word", words.size() > 0 ? words[0] : 64'hX, 64'h0000000000070605);
        chk("restart_wc", 64'(word_count), 64'd1);
        cyc();

        // Reset mid-RUN
        start(10, 0, 0);
        for (int i = 1; i <= 9; i++) send(32'(i));
        chk("mid_wc_pre", 64'(word_count), 64'd1);
        acc_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_busy",  64'(busy), 64'd0);
        chk("mid_ready", 64'(acc_ready), 64'd0);
        chk("mid_wc",    64'(word_count), 64'd0);
        chk("mid_data",  data_from_npu, 64'd0);
        chk("mid_vld",   64'(data_from_npu_valid), 64'd0);
        acc_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
